// File: rtl/seletor_palavras_pkg.sv
// Shared types for the note-word scheduler: note codes, tipo codes,
// sequencer state encoding and the default word length.
package seletor_palavras_pkg;

  localparam int NNOTAS = 5;

  localparam logic [3:0] NOTA_X1    = 4'b0000;
  localparam logic [3:0] NOTA_DO    = 4'b0001;
  localparam logic [3:0] NOTA_RE    = 4'b0010;
  localparam logic [3:0] NOTA_MI    = 4'b0011;
  localparam logic [3:0] NOTA_FA    = 4'b0100;
  localparam logic [3:0] NOTA_SOL   = 4'b0101;
  localparam logic [3:0] NOTA_LA    = 4'b0110;
  localparam logic [3:0] NOTA_SI    = 4'b0111;
  localparam logic [3:0] NOTA_DO2   = 4'b1000;
  localparam logic [3:0] NOTA_RE2   = 4'b1001;
  localparam logic [3:0] NOTA_MI2   = 4'b1010;
  localparam logic [3:0] NOTA_FA2   = 4'b1011;
  localparam logic [3:0] NOTA_SOL_M = 4'b1100;
  localparam logic [3:0] NOTA_FA_M  = 4'b1101;
  localparam logic [3:0] NOTA_LA_M  = 4'b1110;
  localparam logic [3:0] NOTA_SI_M  = 4'b1111;

  typedef enum logic [1:0] {
    TIPO_NULO = 2'b00,
    TIPO_ADJ  = 2'b01,
    TIPO_COMP = 2'b10,
    TIPO_ADV  = 2'b11
  } tipo_e;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_CLEAR  = 3'd1,
    ST_SETUP  = 3'd2,
    ST_STROBE = 3'd3,
    ST_CHECK  = 3'd4,
    ST_DONE   = 3'd5
  } estado_e;

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/seletor_palavras_arbitro.sv
// Two-way round-robin arbiter: grants only while enabled and moves
// priority to the other requester when the served grant completes.
module arbitro_rr2 (
  input  logic       clk,
  input  logic       reset,
  input  logic       req0,
  input  logic       req1,
  input  logic       en,
  input  logic       adv,
  output logic [1:0] gnt
);

  logic ptr_q, ptr_d;
  logic last_q, last_d;

  always_comb begin
    gnt = 2'b00;
    if (en) begin
      if (req0 && req1)
        gnt = ptr_q ? 2'b10 : 2'b01;
      else
        gnt = {req1, req0};
    end
  end

  always_comb begin
    last_d = last_q;
    ptr_d  = ptr_q;
    if (en && (|gnt))
      last_d = gnt[1];
    // favour the requester that was not just served
    if (adv)
      ptr_d = ~last_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ptr_q  <= 1'b0;
      last_q <= 1'b0;
    end else begin
      ptr_q  <= ptr_d;
      last_q <= last_d;
    end
  end

endmodule

// File: rtl/seletor_palavras.sv
// Round-robin scheduler feeding words of notes to the classifier FSM.
// Define SELETOR_ESTAT_EN to add saturating per-tipo result counters.
module seletor_palavras #(
  parameter int NNOTAS = seletor_palavras_pkg::NNOTAS
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                req0,
  input  logic                req1,
  input  logic [4*NNOTAS-1:0] palavra0,
  input  logic [4*NNOTAS-1:0] palavra1,
  output logic                gnt0,
  output logic                gnt1,
  output logic                done0,
  output logic                done1,
  output logic [1:0]          res_tipo,
  output logic                res_erro,
  output logic [2:0]          res_nnotas,
  output logic                cls_reset,
  output logic                cls_ok,
  output logic [3:0]          cls_nota,
  input  logic                cls_fim,
  input  logic [1:0]          cls_tipo
`ifdef SELETOR_ESTAT_EN
  ,
  output logic [7:0]          cnt_adj,
  output logic [7:0]          cnt_comp,
  output logic [7:0]          cnt_adv,
  output logic [7:0]          cnt_erro
`endif
);

  import seletor_palavras_pkg::*;

  localparam int WW = 4 * NNOTAS;
  localparam logic [2:0] IDX_LAST = 3'(NNOTAS - 1);

  estado_e st_q, st_d;
  logic [WW-1:0] word_q, word_d;
  logic [2:0] idx_q, idx_d;
  logic gnt0_q, gnt0_d;
  logic gnt1_q, gnt1_d;
  logic done0_q, done0_d;
  logic done1_q, done1_d;
  logic [1:0] res_tipo_q, res_tipo_d;
  logic res_erro_q, res_erro_d;
  logic [2:0] res_nnotas_q, res_nnotas_d;
  logic cls_reset_q, cls_reset_d;
  logic cls_ok_q, cls_ok_d;
  logic [3:0] cls_nota_q, cls_nota_d;
  logic fin_d;

  logic [1:0] arb_gnt;
  logic arb_en;
  logic arb_adv;

  assign arb_en  = (st_q == ST_IDLE);
  assign arb_adv = (st_q == ST_DONE);

  arbitro_rr2 u_arb (
    .clk   (clk),
    .reset (reset),
    .req0  (req0),
    .req1  (req1),
    .en    (arb_en),
    .adv   (arb_adv),
    .gnt   (arb_gnt)
  );

  always_comb begin
    st_d         = st_q;
    word_d       = word_q;
    idx_d        = idx_q;
    gnt0_d       = gnt0_q;
    gnt1_d       = gnt1_q;
    done0_d      = 1'b0;
    done1_d      = 1'b0;
    res_tipo_d   = res_tipo_q;
    res_erro_d   = res_erro_q;
    res_nnotas_d = res_nnotas_q;
    cls_reset_d  = 1'b0;
    cls_ok_d     = 1'b0;
    cls_nota_d   = cls_nota_q;
    fin_d        = 1'b0;
    unique case (st_q)
      ST_IDLE: begin
        if (|arb_gnt) begin
          st_d        = ST_CLEAR;
          cls_reset_d = 1'b1;
          word_d      = arb_gnt[0] ? palavra0 : palavra1;
          gnt0_d      = arb_gnt[0];
          gnt1_d      = arb_gnt[1];
          idx_d       = 3'd0;
        end
      end
      ST_CLEAR: begin
        st_d       = ST_SETUP;
        cls_nota_d = word_q[3:0];
      end
      ST_SETUP: begin
        st_d     = ST_STROBE;
        cls_ok_d = 1'b1;
      end
      ST_STROBE: begin
        st_d = ST_CHECK;
      end
      ST_CHECK: begin
        if (cls_fim) begin
          res_tipo_d   = cls_tipo;
          res_nnotas_d = idx_q + 3'd1;
          fin_d        = 1'b1;
        end else if (idx_q == IDX_LAST) begin
          // word exhausted without fim: report nulo
          res_tipo_d   = TIPO_NULO;
          res_nnotas_d = idx_q + 3'd1;
          fin_d        = 1'b1;
        end else begin
          idx_d      = idx_q + 3'd1;
          st_d       = ST_SETUP;
          cls_nota_d = word_q[4*(int'(idx_q)+1) +: 4];
        end
        if (fin_d) begin
          st_d       = ST_DONE;
          done0_d    = gnt0_q;
          done1_d    = gnt1_q;
          res_erro_d = (res_tipo_d == TIPO_NULO);
        end
      end
      ST_DONE: begin
        st_d   = ST_IDLE;
        gnt0_d = 1'b0;
        gnt1_d = 1'b0;
      end
      default: st_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      st_q         <= ST_IDLE;
      word_q       <= '0;
      idx_q        <= 3'd0;
      gnt0_q       <= 1'b0;
      gnt1_q       <= 1'b0;
      done0_q      <= 1'b0;
      done1_q      <= 1'b0;
      res_tipo_q   <= 2'b00;
      res_erro_q   <= 1'b0;
      res_nnotas_q <= 3'd0;
      cls_reset_q  <= 1'b1;
      cls_ok_q     <= 1'b0;
      cls_nota_q   <= 4'd0;
    end else begin
      st_q         <= st_d;
      word_q       <= word_d;
      idx_q        <= idx_d;
      gnt0_q       <= gnt0_d;
      gnt1_q       <= gnt1_d;
      done0_q      <= done0_d;
      done1_q      <= done1_d;
      res_tipo_q   <= res_tipo_d;
      res_erro_q   <= res_erro_d;
      res_nnotas_q <= res_nnotas_d;
      cls_reset_q  <= cls_reset_d;
      cls_ok_q     <= cls_ok_d;
      cls_nota_q   <= cls_nota_d;
    end
  end

  assign gnt0       = gnt0_q;
  assign gnt1       = gnt1_q;
  assign done0      = done0_q;
  assign done1      = done1_q;
  assign res_tipo   = res_tipo_q;
  assign res_erro   = res_erro_q;
  assign res_nnotas = res_nnotas_q;
  assign cls_reset  = cls_reset_q;
  assign cls_ok     = cls_ok_q;
  assign cls_nota   = cls_nota_q;

`ifdef SELETOR_ESTAT_EN
  logic [7:0] cnt_adj_q, cnt_adj_d;
  logic [7:0] cnt_comp_q, cnt_comp_d;
  logic [7:0] cnt_adv_q, cnt_adv_d;
  logic [7:0] cnt_erro_q, cnt_erro_d;

  always_comb begin
    cnt_adj_d  = cnt_adj_q;
    cnt_comp_d = cnt_comp_q;
    cnt_adv_d  = cnt_adv_q;
    cnt_erro_d = cnt_erro_q;
    if (fin_d) begin
      unique case (res_tipo_d)
        TIPO_ADJ:  cnt_adj_d  = sat_inc(cnt_adj_q);
        TIPO_COMP: cnt_comp_d = sat_inc(cnt_comp_q);
        TIPO_ADV:  cnt_adv_d  = sat_inc(cnt_adv_q);
        default:   cnt_erro_d = sat_inc(cnt_erro_q);
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_adj_q  <= 8'd0;
      cnt_comp_q <= 8'd0;
      cnt_adv_q  <= 8'd0;
      cnt_erro_q <= 8'd0;
    end else begin
      cnt_adj_q  <= cnt_adj_d;
      cnt_comp_q <= cnt_comp_d;
      cnt_adv_q  <= cnt_adv_d;
      cnt_erro_q <= cnt_erro_d;
    end
  end

  assign cnt_adj  = cnt_adj_q;
  assign cnt_comp = cnt_comp_q;
  assign cnt_adv  = cnt_adv_q;
  assign cnt_erro = cnt_erro_q;
`endif

endmodule

// File: tb/tb_seletor_palavras.sv
// Directed bench for seletor_palavras with a toy note classifier.
module tb_seletor_palavras;
  import seletor_palavras_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset = 1'b1;
  logic req0 = 1'b0, req1 = 1'b0;
  logic [19:0] palavra0 = '0, palavra1 = '0;
  logic gnt0, gnt1, done0, done1;
  logic [1:0] res_tipo;
  logic res_erro;
  logic [2:0] res_nnotas;
  logic cls_reset, cls_ok;
  logic [3:0] cls_nota;
  logic cls_fim;
  logic [1:0] cls_tipo;
`ifdef SELETOR_ESTAT_EN
  logic [7:0] cnt_adj, cnt_comp, cnt_adv, cnt_erro;
`endif

  seletor_palavras #(.NNOTAS(5)) dut (
    .clk        (clk),
    .reset      (reset),
    .req0       (req0),
    .req1       (req1),
    .palavra0   (palavra0),
    .palavra1   (palavra1),
    .gnt0       (gnt0),
    .gnt1       (gnt1),
    .done0      (done0),
    .done1      (done1),
    .res_tipo   (res_tipo),
    .res_erro   (res_erro),
    .res_nnotas (res_nnotas),
    .cls_reset  (cls_reset),
    .cls_ok     (cls_ok),
    .cls_nota   (cls_nota),
    .cls_fim    (cls_fim),
    .cls_tipo   (cls_tipo)
`ifdef SELETOR_ESTAT_EN
    ,
    .cnt_adj    (cnt_adj),
    .cnt_comp   (cnt_comp),
    .cnt_adv    (cnt_adv),
    .cnt_erro   (cnt_erro)
`endif
  );

  // toy classifier: nota_x1 ends the word; the last real note picks tipo
  logic m_fim = 1'b0;
  logic [1:0] m_tipo = 2'b00;
  logic [3:0] m_last = 4'd0;
  int m_cnt = 0;

  always @(posedge clk) begin
    if (cls_reset) begin
      m_fim  <= 1'b0;
      m_tipo <= 2'b00;
      m_last <= 4'd0;
      m_cnt  <= 0;
    end else if (cls_ok && !m_fim) begin
      if (cls_nota == NOTA_X1) begin
        m_fim <= 1'b1;
        if (m_cnt == 0)               m_tipo <= TIPO_NULO;
        else if (m_last == NOTA_LA_M) m_tipo <= TIPO_ADJ;
        else if (m_last == NOTA_DO)   m_tipo <= TIPO_COMP;
        else if (m_last == NOTA_SI_M) m_tipo <= TIPO_ADV;
        else                          m_tipo <= TIPO_NULO;
      end else begin
        m_last <= cls_nota;
        m_cnt  <= m_cnt + 1;
      end
    end
  end

  assign cls_fim  = m_fim;
  assign cls_tipo = m_tipo;

  int n_checks = 0;
  int n_err = 0;

  task automatic check(input string name, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  function automatic logic [19:0] mk(input logic [3:0] a, b, c, d, e);
    return {e, d, c, b, a};
  endfunction

  typedef struct {
    bit         sel;
    logic [19:0] w;
    int         cyc;
    logic [1:0] tipo;
    bit         erro;
    int         nn;
  } vec_t;

  vec_t tv[6];

  // one word on one requester; cycle 0 is the IDLE cycle that samples req
  task automatic run_word(input bit sel, input logic [19:0] w, input int exp_cyc,
                          input logic [1:0] exp_tipo, input bit exp_erro,
                          input int exp_nn);
    int got_cyc;
    int seq_err;
    int other;
    int k;
    int ph;
    logic [19:0] wl;
    wl = w;
    @(negedge clk);
    check("idle_gnt", int'({gnt1, gnt0}), 0);
    check("idle_done", int'({done1, done0}), 0);
    if (sel) begin req1 = 1'b1; palavra1 = w; end
    else     begin req0 = 1'b1; palavra0 = w; end
    got_cyc = -1;
    seq_err = 0;
    other = 0;
    for (int c = 1; c <= 40 && got_cyc < 0; c++) begin
      @(negedge clk);
      if (c == 1) check("clear_cls_reset", int'(cls_reset), 1);
      if (c == 3) begin
        if (sel) begin req1 = 1'b0; palavra1 = ~w; end
        else     begin req0 = 1'b0; palavra0 = ~w; end
      end
      if ((sel ? done0 : done1) || (sel ? gnt0 : gnt1)) other++;
      if ((sel ? gnt1 : gnt0) !== 1'b1) seq_err++;
      if (sel ? done1 : done0) got_cyc = c;
      else if (c >= 2) begin
        k = (c - 2) / 3;
        ph = (c - 2) % 3;
        if (k > 4) seq_err++;
        else if (cls_nota != wl[4*k +: 4] || cls_ok != (ph == 1) || cls_reset)
          seq_err++;
      end
    end
    check("done_cycle", got_cyc, exp_cyc);
    check("note_strobe_seq", seq_err, 0);
    check("other_requester", other, 0);
    if (got_cyc >= 0) begin
      check("res_tipo", int'(res_tipo), int'(exp_tipo));
      check("res_erro", int'(res_erro), int'(exp_erro));
      check("res_nnotas", int'(res_nnotas), exp_nn);
    end
  endtask

  task automatic wait_done(output int who, output int oks);
    int both;
    who = -1;
    oks = 0;
    both = 0;
    for (int c = 0; c < 40 && who < 0; c++) begin
      @(negedge clk);
      if (gnt0 && gnt1) both++;
      if (cls_ok) oks++;
      if (done0) who = 0;
      else if (done1) who = 1;
    end
    check("gnt_exclusive", both, 0);
    if (who < 0) $display("FAIL wait_done: got timeout expected done pulse");
  endtask

  initial begin
    int who;
    int oks;
    int bad;
    logic [19:0] w_adj, w_comp, w_err, w_adv, w_frc;
    w_adj  = mk(NOTA_DO, NOTA_RE, NOTA_LA_M, NOTA_X1, NOTA_X1);
    w_comp = mk(NOTA_DO, NOTA_RE, NOTA_LA_M, NOTA_DO, NOTA_X1);
    w_err  = mk(NOTA_X1, NOTA_DO, NOTA_RE, NOTA_LA_M, NOTA_X1);
    w_adv  = mk(NOTA_DO, NOTA_RE, NOTA_LA_M, NOTA_SI_M, NOTA_X1);
    w_frc  = mk(NOTA_DO, NOTA_RE, NOTA_LA_M, NOTA_SI_M, NOTA_DO);
    tv[0] = '{1'b0, w_adj,  14, TIPO_ADJ,  1'b0, 4};
    tv[1] = '{1'b1, w_comp, 17, TIPO_COMP, 1'b0, 5};
    tv[2] = '{1'b0, w_err,   5, TIPO_NULO, 1'b1, 1};
    tv[3] = '{1'b1, w_adv,  17, TIPO_ADV,  1'b0, 5};
    tv[4] = '{1'b0, w_frc,  17, TIPO_NULO, 1'b1, 5};
    tv[5] = '{1'b1, w_err,   5, TIPO_NULO, 1'b1, 1};

    reset = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("rst_cls_reset", int'(cls_reset), 1);
    check("rst_cls_ok", int'(cls_ok), 0);
    check("rst_cls_nota", int'(cls_nota), 0);
    check("rst_gnt", int'({gnt1, gnt0}), 0);
    check("rst_done", int'({done1, done0}), 0);
    check("rst_res", int'({res_tipo, res_erro, res_nnotas}), 0);
    reset = 1'b0;
    @(negedge clk);
    check("idle_cls_reset_low", int'(cls_reset), 0);

    for (int i = 0; i < 6; i++)
      run_word(tv[i].sel, tv[i].w, tv[i].cyc, tv[i].tipo, tv[i].erro, tv[i].nn);

    // contention from reset
    @(negedge clk);
    reset = 1'b1;
    req0 = 1'b1; palavra0 = w_adj;
    req1 = 1'b1; palavra1 = w_comp;
    @(negedge clk);
    reset = 1'b0;
    wait_done(who, oks);
    check("cont_first", who, 0);
    check("cont_first_oks", oks, 4);
    req0 = 1'b0;
    wait_done(who, oks);
    check("cont_second", who, 1);
    check("cont_second_tipo", int'(res_tipo), int'(TIPO_COMP));
    check("cont_second_oks", oks, 5);
    req0 = 1'b1;
    wait_done(who, oks);
    check("cont_third", who, 0);
    check("cont_third_tipo", int'(res_tipo), int'(TIPO_ADJ));
    req0 = 1'b0;
    wait_done(who, oks);
    check("cont_fourth", who, 1);
    req1 = 1'b0;

    // reset during the strobe of note 2
    @(negedge clk);
    req0 = 1'b1; palavra0 = w_adv;
    for (int c = 1; c <= 9; c++) @(negedge clk);
    check("mid_strobe_ok", int'(cls_ok), 1);
    reset = 1'b1;
    @(negedge clk);
    check("mid_cls_reset", int'(cls_reset), 1);
    check("mid_gnt", int'({gnt1, gnt0}), 0);
    check("mid_cls_ok", int'(cls_ok), 0);
    reset = 1'b0;
    req0 = 1'b0;
    bad = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (done0 || done1 || gnt0 || gnt1) bad++;
    end
    check("mid_no_done", bad, 0);
    run_word(1'b0, w_adv, 17, TIPO_ADV, 1'b0, 5);

`ifdef SELETOR_ESTAT_EN
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("cnt_clear", int'(cnt_adv), 0);
    for (int i = 0; i < 300; i++)
      run_word(i[0], w_adv, 17, TIPO_ADV, 1'b0, 5);
    check("cnt_adv_sat", int'(cnt_adv), 255);
    check("cnt_adj", int'(cnt_adj), 0);
    check("cnt_comp", int'(cnt_comp), 0);
    check("cnt_erro", int'(cnt_erro), 0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/seletor_palavras.md
# seletor_palavras

Two-requester scheduler and sequencer for the note-word classifier FSM. It arbitrates between two note sources using round-robin and latches the granted word of up to five 4-bit notes. It clears the classifier, then feeds the notes one at a time with a clean `ok` strobe and stops on `fim`. It returns the classification (`tipo`) to the granted requester with a one-cycle completion pulse.

## Interface
Parameters:
- `NNOTAS`, 5: maximum notes per word; the word bus is 4·NNOTAS bits.

Ports:
- `clk` in 1: the single clock.
- `reset` in 1: synchronous, active-high.
- `req0`, `req1` in 1: request; held high until the matching `done` pulse.
- `palavra0`, `palavra1` in 20: word; note k is `palavra[4k+3:4k]`, with note 0 played first.
- `gnt0`, `gnt1` out 1: high while that requester is being served.
- `done0`, `done1` out 1: one-cycle completion pulse.
- `res_tipo` out 2: result, with 00 nulo, 01 adj, 10 comp, 11 adv; valid with `done*`.
- `res_erro` out 1: high with `done*` when the result is nulo.
- `res_nnotas` out 3: number of notes fed to the classifier; valid with `done*`.
- `cls_reset` out 1: drives the classifier's `reset`.
- `cls_ok` out 1: drives the classifier's `ok`.
- `cls_nota` out 4: drives the classifier's `nota`.
- `cls_fim` in 1: classifier `fim`.
- `cls_tipo` in 2: classifier `tipo`.

## Operation
- Every output is registered, so `cls_ok` is glitch-free.
- FSM states:
  - IDLE: arbitrate.
  - CLEAR: `cls_reset`=1 for one cycle; latch the word and the grant.
  - SETUP: `cls_nota`=note[idx], `cls_ok`=0.
  - STROBE: `cls_ok`=1, `cls_nota` held.
  - CHECK: `cls_ok`=0, `cls_nota` held; sample `cls_fim`.
  - DONE: pulse `done` for the granted requester; present the results.
- Transitions:
  - IDLE→CLEAR when any `req` is high.
  - CLEAR→SETUP.
  - SETUP→STROBE→CHECK.
  - From CHECK:
    - If `cls_fim`=1, capture `cls_tipo`, set `res_nnotas`=idx+1, go to DONE.
    - Else if idx=NNOTAS-1, force `res_tipo`=00, `res_erro`=1, go to DONE.
    - Else idx++ and go to SETUP.
  - DONE→IDLE.
- Arbitration:
  - A round-robin pointer gives priority to the other requester after each completed grant.
  - When both requests are high in IDLE, the pointer decides.
  - After reset the pointer favours requester 0.
- The word is latched at grant. Dropping `req` or changing `palavra` mid-service has no effect; the word completes and `done` still pulses.
- `res_*` hold their values until the next DONE.
- `res_erro` = (`res_tipo`==00).

## Timing
- Reset values: `cls_reset`=1, `cls_ok`=0, `cls_nota`=0, `gnt*`=0, `done*`=0, `res_tipo`=0, `res_erro`=0, `res_nnotas`=0, pointer=0, FSM=IDLE.
- `cls_reset` falls in the first IDLE cycle after reset deasserts.
- Each note takes 3 cycles.
- Cycle numbering for a word where `fim` is seen after n notes, with the request sampled in IDLE at cycle 0:
  - CLEAR is at cycle 1.
  - Note k occupies cycles 2+3k to 4+3k.
  - `done` pulses at cycle 2+3n.
  - IDLE returns at cycle 3+3n.
- `gnt` is high from CLEAR through DONE inclusive.
- A new request is sampled no earlier than IDLE; there is no back-to-back grant from DONE.
- Reset mid-operation: the next edge returns to IDLE with `cls_reset`=1. No `done` is issued for the aborted word. The pointer is reset to 0.

## Configuration
- `SELETOR_ESTAT_EN`, when defined:
  - Adds four 8-bit saturating counters and output ports: `cnt_adj`, `cnt_comp`, `cnt_adv`, `cnt_erro`.
  - Each counter increments in DONE according to `res_tipo`.
  - Counters hold at 255 and clear on `reset`.
- When not defined, the counters and their ports are absent; all other behaviour is identical.

## Structure
- Shared package contents:
  - Note codes: nota_x1=0000, do=0001, re=0010, la_m=1110, si_m=1111, and the rest of the set.
  - `tipo` codes.
  - The FSM state encoding.
  - NNOTAS.
- One sub-module, `arbitro_rr2`:
  - Holds the two-way round-robin pointer.
  - Inputs: `req0`, `req1`, an enable (IDLE) and an advance (DONE).
  - Output: a one-hot grant.

## Test plan
- Adjective: `req0`, notes do, re, la_m, nota_x1 → `done0` at cycle 14; `res_tipo`=01, `res_nnotas`=4, `res_erro`=0.
- Comparative: `req1`, notes do, re, la_m, do, nota_x1 → `done1` at cycle 17; `res_tipo`=10, `res_nnotas`=5.
- Error: note 0 = nota_x1 → `done` at cycle 5; `res_tipo`=00, `res_erro`=1, `res_nnotas`=1.
- Contention: `req0` and `req1` both high from reset → requester 0 served first, then requester 1; then both re-raised → requester 0 served again after requester 1. Check that `cls_ok` strobes exactly once per note with `cls_nota` stable for the whole SETUP–CHECK window.
- Reset mid-word: assert `reset` during the STROBE of note 2 → next cycle IDLE with `cls_reset`=1 and no `done`. The subsequent word classifies correctly.
- With `SELETOR_ESTAT_EN`: 300 adverb words (do, re, la_m, si_m, nota_x1) → `cnt_adv`=255 and the other counters 0.
